seq_stack: RTL and testbench

//  Parametrised LIFO sequence store for the Simon game datapath: stack push/pop, plus an

---
 rtl/seq_stack_pkg.sv | 16 +
 rtl/stack_regfile.sv | 42 ++++
 rtl/seq_stack.sv | 147 ++++++++++++++
 tb/tb_seq_stack.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_stack_pkg.sv
// Shared helpers for the Simon sequence store.
package seq_stack_pkg;

    // Ceiling log2, used to size occupancy and pointer fields at elaboration.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Flop-based entry storage: one write port, two asynchronous read ports (top and replay).
module stack_regfile #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 5
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_top_addr,
    output logic [DATA_WIDTH-1:0] o_top_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Entry write; storage is not reset because every reader gates by occupancy.
    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_we && (i_waddr == AW'(i))) begin
                r_mem[i] <= i_wdata;
            end
        end
    end

    // Decoded reads; an address at or beyond DEPTH reads as zero.
    always_comb begin
        o_top_data = '0;
        o_rd_data  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_top_addr == AW'(i)) begin
                o_top_data = r_mem[i];
            end
            if (i_rd_addr == AW'(i)) begin
                o_rd_data = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/seq_stack.sv
// LIFO colour-sequence store with a bottom-up replay port, occupancy count and sticky errors.
module seq_stack
    import seq_stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned CW        = clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    output logic [DATA_WIDTH-1:0] o_data_out,
    input  logic                  i_rewind,
    input  logic                  i_next,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_rd_last,
    output logic [CW-1:0]         o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [CW-1:0]         w_count_d;
    logic [CW-1:0]         w_ptr_d;
    logic                  w_overflow_d;
    logic                  w_underflow_d;
    logic                  w_we;
    logic [CW-1:0]         w_waddr;
    logic [CW-1:0]         w_top_addr;
    logic [DATA_WIDTH-1:0] w_top_data;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_valid;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_rd_valid = (r_ptr < r_count);
    assign w_top_addr = r_count - CW'(1);

    stack_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (CW)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (i_data_in),
        .i_top_addr (w_top_addr),
        .o_top_data (w_top_data),
        .i_rd_addr  (r_ptr),
        .o_rd_data  (w_rd_data)
    );

    // Next-state for count, replay pointer, flags and the storage write.
    always_comb begin
        w_count_d     = r_count;
        w_ptr_d       = r_ptr;
        w_overflow_d  = r_overflow;
        w_underflow_d = r_underflow;
        w_we          = 1'b0;
        w_waddr       = r_count;
        if (i_clear) begin
            w_count_d     = '0;
            w_ptr_d       = '0;
            w_overflow_d  = 1'b0;
            w_underflow_d = 1'b0;
        end else begin
            unique case ({i_push, i_pop})
                2'b10: begin
                    if (w_full) begin
                        w_overflow_d = 1'b1;
                    end else begin
                        w_we      = 1'b1;
                        w_count_d = r_count + CW'(1);
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        w_underflow_d = 1'b1;
                    end else begin
                        w_count_d = r_count - CW'(1);
                    end
                end
                2'b11: begin
                    w_we = 1'b1;
                    if (w_empty) begin
                        w_count_d = r_count + CW'(1);
                    end else begin
                        // Replace top in place; legal even when full.
                        w_waddr = w_top_addr;
                    end
                end
                default: ;
            endcase
            if (i_rewind) begin
                w_ptr_d = '0;
            end else if (i_next && w_rd_valid) begin
                w_ptr_d = r_ptr + CW'(1);
            end
            // A pop may leave the pointer past the new top; pull it back to COUNT.
            if (w_ptr_d > w_count_d) begin
                w_ptr_d = w_count_d;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_ptr       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_d;
            r_ptr       <= w_ptr_d;
            r_overflow  <= w_overflow_d;
            r_underflow <= w_underflow_d;
        end
    end

    // Outputs come from registered state only; data gated so unwritten entries never leak.
    always_comb begin
        o_data_out  = w_empty ? '0 : w_top_data;
        o_rd_data   = w_rd_valid ? w_rd_data : '0;
        o_rd_valid  = w_rd_valid;
        o_rd_last   = w_rd_valid && (r_ptr == w_top_addr);
        o_count     = r_count;
        o_full      = w_full;
        o_empty     = w_empty;
        o_overflow  = r_overflow;
        o_underflow = r_underflow;
    end

endmodule

// File: tb/tb_seq_stack.sv
// Self-checking bench for seq_stack: queue-based reference model plus directed literal checks.
module tb_seq_stack;

    localparam int unsigned DW = 2;
    localparam int unsigned D4 = 4;

    logic       clk;
    logic       rst_n;
    logic       clear, push, pop, rewind, next;
    logic [1:0] din;
    logic [1:0] data_out, rd_data;
    logic       rd_valid, rd_last, full, empty, overflow, underflow;
    logic [2:0] count;

    logic       push5, rewind5;
    logic [1:0] din5;
    logic [1:0] data_out5, rd_data5;
    logic       rd_valid5, rd_last5, full5, empty5, overflow5, underflow5;
    logic [2:0] count5;
    logic       tie0;

    int n_checks;
    int n_fail;
    bit cmp_en;

    // Reference model state
    logic [1:0] m_stack[$];
    int         m_ptr;
    bit         m_ovf;
    bit         m_unf;

    seq_stack #(.DATA_WIDTH(DW), .DEPTH(D4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (clear),
        .i_push      (push),
        .i_pop       (pop),
        .i_data_in   (din),
        .o_data_out  (data_out),
        .i_rewind    (rewind),
        .i_next      (next),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_rd_last   (rd_last),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty),
        .o_overflow  (overflow),
        .o_underflow (underflow)
    );

    seq_stack #(.DATA_WIDTH(DW), .DEPTH(5)) dut5 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (tie0),
        .i_push      (push5),
        .i_pop       (tie0),
        .i_data_in   (din5),
        .o_data_out  (data_out5),
        .i_rewind    (rewind5),
        .i_next      (tie0),
        .o_rd_data   (rd_data5),
        .o_rd_valid  (rd_valid5),
        .o_rd_last   (rd_last5),
        .o_count     (count5),
        .o_full      (full5),
        .o_empty     (empty5),
        .o_overflow  (overflow5),
        .o_underflow (underflow5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_ptr = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    // One clock edge of the behavioural rules, applied to the held inputs.
    task automatic model_step();
        int old_sz;
        old_sz = m_stack.size();
        if (clear) begin
            model_reset();
        end else begin
            if (push && !pop) begin
                if (old_sz == D4) m_ovf = 1;
                else m_stack.push_back(din);
            end else if (!push && pop) begin
                if (old_sz == 0) m_unf = 1;
                else void'(m_stack.pop_back());
            end else if (push && pop) begin
                if (old_sz == 0) m_stack.push_back(din);
                else m_stack[old_sz-1] = din;
            end
            if (rewind) m_ptr = 0;
            else if (next && m_ptr < old_sz) m_ptr++;
            if (m_ptr > m_stack.size()) m_ptr = m_stack.size();
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then return to idle.
    task automatic cyc(input logic p, input logic q, input logic [1:0] d,
                       input logic rw, input logic nx, input logic cl);
        push = p; pop = q; din = d; rewind = rw; next = nx; clear = cl;
        @(posedge clk);
        model_step();
        #1;
        push = 0; pop = 0; din = 0; rewind = 0; next = 0; clear = 0;
    endtask

    // Continuous comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            int sz;
            sz = m_stack.size();
            chk("m_data_out", data_out, (sz > 0) ? m_stack[sz-1] : 2'd0);
            chk("m_rd_data", rd_data, (m_ptr < sz) ? m_stack[m_ptr] : 2'd0);
            chk("m_rd_valid", rd_valid, m_ptr < sz);
            chk("m_rd_last", rd_last, (m_ptr < sz) && (m_ptr == sz - 1));
            chk("m_count", count, sz);
            chk("m_full", full, sz == D4);
            chk("m_empty", empty, sz == 0);
            chk("m_overflow", overflow, m_ovf);
            chk("m_underflow", underflow, m_unf);
        end
    end

    initial begin
        logic [1:0] seq4 [4];
        logic [1:0] seq5 [5];
        n_checks = 0; n_fail = 0; cmp_en = 0; tie0 = 0;
        push = 0; pop = 0; din = 0; rewind = 0; next = 0; clear = 0;
        push5 = 0; din5 = 0; rewind5 = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cmp_en = 1;

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_rd_valid", rd_valid, 0);

        // Fill and overflow
        seq4 = '{2'd1, 2'd2, 2'd3, 2'd0};
        foreach (seq4[i]) cyc(1, 0, seq4[i], 0, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_top", data_out, 0);
        cyc(1, 0, 2'd2, 0, 0, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 4);
        chk("ovf_top", data_out, 0);

        // Drain and underflow, then clear
        cyc(0, 1, 0, 0, 0, 0); chk("pop1_top", data_out, 3);
        cyc(0, 1, 0, 0, 0, 0); chk("pop2_top", data_out, 2);
        cyc(0, 1, 0, 0, 0, 0); chk("pop3_top", data_out, 1);
        cyc(0, 1, 0, 0, 0, 0); chk("pop4_empty", empty, 1);
        cyc(0, 1, 0, 0, 0, 0); chk("unf_flag", underflow, 1);
        chk("unf_count", count, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr_ovf", overflow, 0);
        chk("clr_unf", underflow, 0);

        // Replace on full, push&pop on empty
        foreach (seq4[i]) cyc(1, 0, seq4[i], 0, 0, 0);
        cyc(1, 1, 2'd2, 0, 0, 0);
        chk("rep_count", count, 4);
        chk("rep_top", data_out, 2);
        chk("rep_ovf", overflow, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 1, 2'd3, 0, 0, 0);
        chk("pp_empty_count", count, 1);
        chk("pp_empty_top", data_out, 3);
        chk("pp_empty_unf", underflow, 0);

        // Replay walk
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 2'd1, 0, 0, 0);
        cyc(1, 0, 2'd2, 0, 0, 0);
        cyc(1, 0, 2'd3, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0); chk("rp0_data", rd_data, 1);
        cyc(0, 0, 0, 0, 1, 0); chk("rp1_data", rd_data, 2);
        cyc(0, 0, 0, 0, 1, 0); chk("rp2_data", rd_data, 3);
        chk("rp2_last", rd_last, 1);
        cyc(0, 0, 0, 0, 1, 0); chk("rp3_valid", rd_valid, 0);
        cyc(0, 0, 0, 0, 1, 0); chk("rp_extra_valid", rd_valid, 0);
        cyc(0, 0, 0, 1, 1, 0); chk("rp_rw_next_data", rd_data, 1);
        chk("rp_rw_next_last", rd_last, 0);

        // Pointer clamp on pop
        cyc(1, 0, 2'd0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 0);
        chk("cl_ptr3_data", rd_data, 0);
        chk("cl_ptr3_last", rd_last, 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("cl_count", count, 2);
        chk("cl_valid", rd_valid, 0);
        cyc(1, 0, 2'd1, 0, 0, 0);
        chk("cl_push_data", rd_data, 1);
        chk("cl_push_last", rd_last, 1);

        // Asynchronous reset mid-stream with three entries
        cyc(0, 0, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 2'd2, 0, 0, 0);
        chk("pre_rst_count", count, 3);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_data_out", data_out, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_rd_valid", rd_valid, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // DEPTH=5 instance: fill, then a sixth push must not wrap
        seq5 = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        foreach (seq5[i]) begin
            push5 = 1; din5 = seq5[i];
            @(posedge clk); #1;
        end
        push5 = 0;
        chk("d5_full", full5, 1);
        chk("d5_count", count5, 5);
        chk("d5_top", data_out5, 1);
        push5 = 1; din5 = 2'd2;
        @(posedge clk); #1;
        push5 = 0; rewind5 = 1;
        @(posedge clk); #1;
        rewind5 = 0;
        chk("d5_ovf", overflow5, 1);
        chk("d5_count_after", count5, 5);
        chk("d5_top_after", data_out5, 1);
        chk("d5_bottom", rd_data5, 3);

        repeat (2) @(posedge clk);
        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
